// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with serial slave-address decode and single split tracking.
// Drives grant and one-hot slave-select lines; data moves on the shared serial line.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 3,
    parameter int SLV_ADDR_W    = 2,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NUM_MASTERS-1:0] B_REQ,
    output logic [NUM_MASTERS-1:0] B_GRANT,
    input  logic                   B_UTIL,
    input  logic                   A_ADD,
    input  logic                   B_BUS_OUT,
    input  logic [NUM_SLAVES-1:0]  B_SBSY,
    input  logic                   B_SPLIT,
    input  logic                   B_SPL_RESUME,
    input  logic                   B_DONE,
    output logic [NUM_SLAVES-1:0]  AD_SEL,
    output logic                   B_ADDR_ERR,
    output logic                   B_SPL_PEND,
    output logic [2:0]             DBG_STATE
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(SLV_ADDR_W + 2);
    localparam int TW = $clog2(GRANT_TIMEOUT);
    localparam logic [SLV_ADDR_W:0] NS_LIM = NUM_SLAVES[SLV_ADDR_W:0];

    // Handshake: B_REQ is a level request; B_GRANT stays high until the owner
    // finishes, splits, aborts (B_UTIL low) or the grant times out, and at
    // least one idle cycle separates two owners.
    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ADDR, S_WAIT_SLV, S_DATA} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [MW-1:0]           mst_q, mst_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    err_q, err_d;
    logic [MW-1:0]           ptr_q, ptr_d;
    logic [SLV_ADDR_W-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]           bcnt_q, bcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [SLV_ADDR_W-1:0]   slv_q, slv_d;
    logic                    pend_q, pend_d;
    logic [MW-1:0]           spl_mst_q, spl_mst_d;
    logic [SLV_ADDR_W-1:0]   spl_slv_q, spl_slv_d;
    logic                    rsm_q, rsm_d;

    logic [NUM_MASTERS-1:0]  req_m;
    logic [MW-1:0]           cand, pick;
    logic                    found, release_bus, addr_bad;

    assign addr_bad = (bcnt_q != CW'(SLV_ADDR_W)) || ({1'b0, shreg_q} >= NS_LIM);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            mst_q     <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
            ptr_q     <= MW'(NUM_MASTERS - 1);
            shreg_q   <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            slv_q     <= '0;
            pend_q    <= 1'b0;
            spl_mst_q <= '0;
            spl_slv_q <= '0;
            rsm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            mst_q     <= mst_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            shreg_q   <= shreg_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
            slv_q     <= slv_d;
            pend_q    <= pend_d;
            spl_mst_q <= spl_mst_d;
            spl_slv_q <= spl_slv_d;
            rsm_q     <= rsm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mst_d       = mst_q;
        sel_d       = sel_q;
        err_d       = 1'b0;
        ptr_d       = ptr_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        tcnt_d      = tcnt_q;
        slv_d       = slv_q;
        pend_d      = pend_q;
        spl_mst_d   = spl_mst_q;
        spl_slv_d   = spl_slv_q;
        rsm_d       = rsm_q | (pend_q & B_SPL_RESUME);
        release_bus = 1'b0;
        cand        = '0;
        pick        = '0;
        found       = 1'b0;

        // The split master may not re-enter through round-robin while its split is open.
        req_m = B_REQ;
        if (pend_q) req_m[spl_mst_q] = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = MW'((int'(ptr_q) + i) % NUM_MASTERS);
            if (!found && req_m[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q && rsm_q) begin
                    gnt_d            = '0;
                    gnt_d[spl_mst_q] = 1'b1;
                    mst_d            = spl_mst_q;
                    sel_d            = '0;
                    sel_d[spl_slv_q] = 1'b1;
                    slv_d            = spl_slv_q;
                    pend_d           = 1'b0;
                    rsm_d            = 1'b0;
                    state_d          = S_DATA;
                end else if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    mst_d       = pick;
                    shreg_d     = '0;
                    bcnt_d      = '0;
                    tcnt_d      = '0;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (B_UTIL) begin
                    state_d = S_ADDR;
                end else if (!B_REQ[mst_q] || tcnt_q == TW'(GRANT_TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_ADDR: begin
                if (!B_UTIL) begin
                    release_bus = 1'b1;
                end else if (A_ADD) begin
                    shreg_d = (shreg_q << 1) | SLV_ADDR_W'(B_BUS_OUT);
                    if (bcnt_q != CW'(SLV_ADDR_W + 1)) bcnt_d = bcnt_q + 1'b1;
                end else if (bcnt_q != '0) begin
                    if (addr_bad) begin
                        err_d       = 1'b1;
                        release_bus = 1'b1;
                    end else begin
                        slv_d = shreg_q;
                        if (B_SBSY[shreg_q]) begin
                            state_d = S_WAIT_SLV;
                        end else begin
                            sel_d          = '0;
                            sel_d[shreg_q] = 1'b1;
                            state_d        = S_DATA;
                        end
                    end
                end
            end
            S_WAIT_SLV: begin
                if (!B_UTIL) begin
                    release_bus = 1'b1;
                end else if (!B_SBSY[slv_q]) begin
                    sel_d        = '0;
                    sel_d[slv_q] = 1'b1;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (B_DONE) begin
                    release_bus = 1'b1;
                end else if (B_SPLIT && !pend_q) begin
                    pend_d      = 1'b1;
                    spl_mst_d   = mst_q;
                    spl_slv_d   = slv_q;
                    release_bus = 1'b1;
                end else if (!B_UTIL) begin
                    release_bus = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every normal end of ownership hands the round-robin pointer to the owner.
        if (release_bus) begin
            gnt_d   = '0;
            sel_d   = '0;
            ptr_d   = mst_q;
            state_d = S_IDLE;
        end
    end

    assign B_GRANT    = gnt_q;
    assign AD_SEL     = sel_q;
    assign B_ADDR_ERR = err_q;
    assign B_SPL_PEND = pend_q;
    assign DBG_STATE  = state_q;

endmodule
